// File: rtl/adma_pkg.sv
// adma_pkg: shared requester indices and arbiter state encoding for the ADMA
// Wishbone master arbiter.
package adma_pkg;

  localparam int REQ_DESC = 0;
  localparam int REQ_SRC  = 1;
  localparam int REQ_DST  = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/adma_rr_pick.sv
// adma_rr_pick: combinational round-robin selector; returns a one-hot grant for
// the first requesting index at or after last_i+1, wrapping modulo NREQ.
module adma_rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk the ring starting just after the previous owner; the first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDX_W'((int'(last_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adma_wbm_arb.sv
// adma_wbm_arb: round-robin arbiter sharing one Wishbone master among NREQ DMA
// requesters. Define ADMA_ARB_TMO_EN to add the stalled-slave bus timeout.
module adma_wbm_arb
  import adma_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int TMO_W = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NREQ-1:0]    req_cyc_i,
  input  logic [NREQ-1:0]    req_stb_i,
  input  logic [NREQ-1:0]    req_we_i,
  input  logic [NREQ-1:0]    req_cab_i,
  input  logic [32*NREQ-1:0] req_adr_i,
  input  logic [4*NREQ-1:0]  req_sel_i,
  input  logic [64*NREQ-1:0] req_dat_i,
  output logic [NREQ-1:0]    req_ack_o,
  output logic [NREQ-1:0]    req_err_o,
  output logic [NREQ-1:0]    req_rty_o,
  output logic [63:0]        rd_dat_o,
  output logic [NREQ-1:0]    grant_o,
`ifdef ADMA_ARB_TMO_EN
  output logic               tmo_o,
`endif
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic               wbm_cab_o,
  output logic [31:0]        wbm_adr_o,
  output logic [3:0]         wbm_sel_o,
  output logic [31:0]        wbm_dat_o,
  output logic [31:0]        wbm_dat64_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  input  logic [31:0]        wbm_dat_i,
  input  logic [31:0]        wbm_dat64_i
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] owner_idx;
  logic             owner_cyc;
  logic             busy;
  logic             aborted;
  logic             tmo_hit;
  logic             term_en;

  adma_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign busy      = (state_q == ARB_BUSY);
  assign owner_cyc = |(req_cyc_i & grant_q);
  assign grant_o   = grant_q;
  assign rd_dat_o  = {wbm_dat64_i, wbm_dat_i};

  // grant_q is all-zero outside BUSY, so the mux naturally idles the bus.
  always_comb begin
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_cab_o   = 1'b0;
    wbm_adr_o   = '0;
    wbm_sel_o   = '0;
    wbm_dat_o   = '0;
    wbm_dat64_o = '0;
    owner_idx   = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (grant_q[n]) begin
        wbm_cyc_o   = req_cyc_i[n] & ~aborted;
        wbm_stb_o   = req_stb_i[n] & ~aborted;
        wbm_we_o    = req_we_i[n]  & ~aborted;
        wbm_cab_o   = req_cab_i[n] & ~aborted;
        wbm_adr_o   = req_adr_i[32*n +: 32];
        wbm_sel_o   = req_sel_i[4*n +: 4];
        wbm_dat_o   = req_dat_i[64*n +: 32];
        wbm_dat64_o = req_dat_i[64*n+32 +: 32];
        owner_idx   = IDX_W'(n);
      end
    end
  end

  // Terminations are suppressed during reset and after a timeout abort.
  assign term_en   = busy & ~aborted & ~wb_rst_i;
  assign req_ack_o = grant_q & {NREQ{term_en & wbm_ack_i}};
  assign req_err_o = grant_q & {NREQ{term_en & (wbm_err_i | tmo_hit)}};
  assign req_rty_o = grant_q & {NREQ{term_en & wbm_rty_i}};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req_cyc_i) begin
            grant_q <= pick;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!owner_cyc) begin
            grant_q <= '0;
            last_q  <= owner_idx;
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ADMA_ARB_TMO_EN
  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic             abort_q;
  logic             tmo_q;
  logic             stall;

  assign stall   = busy & wbm_stb_o & ~(wbm_ack_i | wbm_err_i | wbm_rty_i);
  assign tmo_hit = stall & (cnt_q == CNT_MAX);
  assign cnt_d   = (stall & ~tmo_hit) ? cnt_q + 1'b1 : '0;
  assign aborted = abort_q;
  assign tmo_o   = tmo_q;

  // Abort holds the bus released until the owner gives up its cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (tmo_hit) begin
        abort_q <= 1'b1;
        tmo_q   <= 1'b1;
      end else if (!busy) begin
        abort_q <= 1'b0;
      end
    end
  end
`else
  assign aborted = 1'b0;
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_adma_wbm_arb.sv
// tb_adma_wbm_arb: table-driven bench for adma_wbm_arb plus hand-written
// timeout / stall sequences (ADMA_ARB_TMO_EN selects which one runs).
module tb_adma_wbm_arb;

  localparam int NREQ = 3;

  logic               wb_clk_i;
  logic               wb_rst_i;
  logic [NREQ-1:0]    req_cyc_i;
  logic [NREQ-1:0]    req_stb_i;
  logic [NREQ-1:0]    req_we_i;
  logic [NREQ-1:0]    req_cab_i;
  logic [32*NREQ-1:0] req_adr_i;
  logic [4*NREQ-1:0]  req_sel_i;
  logic [64*NREQ-1:0] req_dat_i;
  logic [NREQ-1:0]    req_ack_o;
  logic [NREQ-1:0]    req_err_o;
  logic [NREQ-1:0]    req_rty_o;
  logic [63:0]        rd_dat_o;
  logic [NREQ-1:0]    grant_o;
  logic               tmo_o;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic               wbm_we_o;
  logic               wbm_cab_o;
  logic [31:0]        wbm_adr_o;
  logic [3:0]         wbm_sel_o;
  logic [31:0]        wbm_dat_o;
  logic [31:0]        wbm_dat64_o;
  logic               wbm_ack_i;
  logic               wbm_err_i;
  logic               wbm_rty_i;
  logic [31:0]        wbm_dat_i;
  logic [31:0]        wbm_dat64_i;

  adma_wbm_arb #(
    .NREQ  (NREQ),
    .TMO_W (8)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .req_cyc_i   (req_cyc_i),
    .req_stb_i   (req_stb_i),
    .req_we_i    (req_we_i),
    .req_cab_i   (req_cab_i),
    .req_adr_i   (req_adr_i),
    .req_sel_i   (req_sel_i),
    .req_dat_i   (req_dat_i),
    .req_ack_o   (req_ack_o),
    .req_err_o   (req_err_o),
    .req_rty_o   (req_rty_o),
    .rd_dat_o    (rd_dat_o),
    .grant_o     (grant_o),
`ifdef ADMA_ARB_TMO_EN
    .tmo_o       (tmo_o),
`endif
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_cab_o   (wbm_cab_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat64_o (wbm_dat64_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .wbm_rty_i   (wbm_rty_i),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_dat64_i (wbm_dat64_i)
  );

`ifndef ADMA_ARB_TMO_EN
  assign tmo_o = 1'b0;
`endif

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        rst;
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic        ack;
    logic        err;
    logic        rty;
    logic [2:0]  eGrant;
    logic        eCyc;
    logic        eWe;
    logic [2:0]  eAck;
    logic [2:0]  eErr;
    logic [2:0]  eRty;
    logic [31:0] eAdr;
  } vec_t;

  vec_t vecs[$];
  int   nApplied;
  int   nMiscompares;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    wb_rst_i    = v.rst;
    req_cyc_i   = v.cyc;
    req_stb_i   = v.stb;
    wbm_ack_i   = v.ack;
    wbm_err_i   = v.err;
    wbm_rty_i   = v.rty;
    wbm_dat_i   = 32'hA000_0000 + 32'(i);
    wbm_dat64_i = 32'hB000_0000 + 32'(i);
    nApplied++;
  endtask

  initial begin
    int hitAt;
    int badStall;

    nApplied     = 0;
    nMiscompares = 0;
    wb_rst_i     = 1'b1;
    req_cyc_i    = '0;
    req_stb_i    = '0;
    req_we_i     = 3'b100;
    req_cab_i    = '0;
    req_adr_i    = {32'h0000_0500, 32'h0000_0200, 32'h0000_0100};
    req_sel_i    = {4'hC, 4'h3, 4'hF};
    req_dat_i    = {32'hD2D2_0064, 32'hD2D2_0032, 32'hD1D1_0064, 32'hD1D1_0032,
                    32'hD0D0_0064, 32'hD0D0_0032};
    wbm_ack_i    = 1'b0;
    wbm_err_i    = 1'b0;
    wbm_rty_i    = 1'b0;
    wbm_dat_i    = '0;
    wbm_dat64_i  = '0;

    //             rst cyc     stb     ack   err   rty   eGrant  eCyc  eWe   eAck    eErr    eRty    eAdr
    // single owner: req 1 reads 4 beats at 0x200
    vecs.push_back('{1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 3'b000, 32'h200});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h200});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    // fairness after a fresh reset: 001, 010, 100 with an idle cycle between
    vecs.push_back('{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    for (int k = 0; k < 2; k++)
      vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 32'h100});
    vecs.push_back('{1'b0, 3'b110, 3'b110, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h100});
    vecs.push_back('{1'b0, 3'b110, 3'b110, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    for (int k = 0; k < 2; k++)
      vecs.push_back('{1'b0, 3'b110, 3'b110, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 3'b000, 32'h200});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h200});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    // err then rty on req 2 write at 0x500; grant held until cyc drops
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 3'b000, 3'b100, 3'b000, 32'h500});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 32'h500});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 3'b000, 3'b000, 3'b100, 32'h500});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 32'h500});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    // rotation: req 0 releases while req 2 pends, req 1 idle
    vecs.push_back('{1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    vecs.push_back('{1'b0, 3'b101, 3'b101, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 32'h100});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h100});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 3'b100, 3'b000, 3'b000, 32'h500});
    // req 1 pulses cyc while req 2 owns: it must be forgotten
    vecs.push_back('{1'b0, 3'b110, 3'b110, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 32'h500});
    vecs.push_back('{1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 3'b100, 3'b000, 3'b000, 32'h500});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 32'h500});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    // reset mid-burst: no ack forwarded, next grant to requester 0
    vecs.push_back('{1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 3'b000, 32'h200});
    vecs.push_back('{1'b1, 3'b011, 3'b011, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 32'h200});
    vecs.push_back('{1'b0, 3'b011, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});
    vecs.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 32'h100});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h100});
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0});

    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    nApplied++;
    checkOutput("reset_grant", 64'(grant_o), 64'h0);
    checkOutput("reset_cyc", 64'(wbm_cyc_o), 64'h0);
    checkOutput("reset_tmo", 64'(tmo_o), 64'h0);

    foreach (vecs[i]) begin
      @(posedge wb_clk_i);
      #1;
      applyStimulus(vecs[i], i);
      @(negedge wb_clk_i);
      checkOutput($sformatf("v%0d_grant", i), 64'(grant_o), 64'(vecs[i].eGrant));
      checkOutput($sformatf("v%0d_cyc", i), 64'(wbm_cyc_o), 64'(vecs[i].eCyc));
      checkOutput($sformatf("v%0d_we", i), 64'(wbm_we_o), 64'(vecs[i].eWe));
      checkOutput($sformatf("v%0d_ack", i), 64'(req_ack_o), 64'(vecs[i].eAck));
      checkOutput($sformatf("v%0d_err", i), 64'(req_err_o), 64'(vecs[i].eErr));
      checkOutput($sformatf("v%0d_rty", i), 64'(req_rty_o), 64'(vecs[i].eRty));
      if (vecs[i].eGrant != 3'b000)
        checkOutput($sformatf("v%0d_adr", i), 64'(wbm_adr_o), 64'(vecs[i].eAdr));
      if (vecs[i].eAck != 3'b000)
        checkOutput($sformatf("v%0d_rdat", i), rd_dat_o,
                    {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)});
    end

    // Stalled slave: req 0 strobes with no response at all.
    @(posedge wb_clk_i);
    #1;
    wb_rst_i  = 1'b1;
    req_cyc_i = '0;
    req_stb_i = '0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i  = 1'b0;
    req_cyc_i = 3'b001;
    req_stb_i = 3'b001;
    @(posedge wb_clk_i);
    nApplied++;
    hitAt    = 0;
    badStall = 0;
`ifdef ADMA_ARB_TMO_EN
    for (int k = 1; k <= 400; k++) begin
      @(negedge wb_clk_i);
      if (req_err_o != 3'b000) begin
        hitAt = k;
        break;
      end
    end
    checkOutput("tmo_cycle", 64'(hitAt), 64'd256);
    checkOutput("tmo_err_owner", 64'(req_err_o), 64'h1);
    @(negedge wb_clk_i);
    checkOutput("tmo_flag", 64'(tmo_o), 64'h1);
    checkOutput("tmo_cyc_low", 64'(wbm_cyc_o), 64'h0);
    checkOutput("tmo_err_pulse", 64'(req_err_o), 64'h0);
    checkOutput("tmo_grant_held", 64'(grant_o), 64'h1);
    @(posedge wb_clk_i);
    #1;
    req_cyc_i = '0;
    req_stb_i = '0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("tmo_idle_grant", 64'(grant_o), 64'h0);
    checkOutput("tmo_sticky", 64'(tmo_o), 64'h1);
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checkOutput("tmo_reset_clear", 64'(tmo_o), 64'h0);
`else
    for (int k = 1; k <= 300; k++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o !== 1'b1 || req_err_o !== 3'b000 || grant_o !== 3'b001)
        badStall++;
    end
    checkOutput("stall_held", 64'(badStall), 64'h0);
    checkOutput("stall_no_hit", 64'(hitAt), 64'h0);
    @(posedge wb_clk_i);
    #1;
    req_cyc_i = '0;
    req_stb_i = '0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("stall_release", 64'(grant_o), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule

// File: doc/adma_wbm_arb.md
ADMA_WBM_ARB -- requirements
Module: adma_wbm_arb

Interface
REQ-001 Parameter NREQ, default 3, number of requesters; index 0 = descriptor fetch, 1 = source read, 2 = destination write.
REQ-002 Parameter TMO_W, default 8, width of the bus-timeout counter; timeout limit = 2**TMO_W cycles.
REQ-003 wb_clk_i  in  1  sole clock.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_cyc_i  in  NREQ  per-requester cycle.
REQ-006 req_stb_i  in  NREQ  per-requester strobe.
REQ-007 req_we_i  in  NREQ  per-requester write enable.
REQ-008 req_cab_i  in  NREQ  per-requester burst flag.
REQ-009 req_adr_i  in  32*NREQ  packed addresses; requester n uses [32n+31:32n].
REQ-010 req_sel_i  in  4*NREQ  packed byte selects.
REQ-011 req_dat_i  in  64*NREQ  packed write data; {dat64, dat} per requester.
REQ-012 req_ack_o, req_err_o, req_rty_o  out  NREQ each  per-requester terminations.
REQ-013 rd_dat_o  out  64  {wbm_dat64_i, wbm_dat_i}, broadcast to all requesters.
REQ-014 grant_o  out  NREQ  one-hot current owner; zero when idle.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o  out  1 each  shared master control.
REQ-016 wbm_adr_o  out  32;  wbm_sel_o  out  4;  wbm_dat_o, wbm_dat64_o  out  32 each.
REQ-017 wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each;  wbm_dat_i, wbm_dat64_i  in  32 each.
REQ-018 tmo_o  out  1  sticky bus-timeout flag (present only with ADMA_ARB_TMO_EN).

Function
REQ-019 FSM has two states: IDLE and BUSY.
REQ-020 In IDLE, if any req_cyc_i bit is set, the arbiter registers a one-hot grant to the first requester at or after last_owner+1 (mod NREQ) and enters BUSY; arbitration latency is one cycle.
REQ-021 In IDLE, all wbm_* control outputs are 0 and grant_o = 0.
REQ-022 In BUSY, wbm_cyc/stb/we/cab/adr/sel/dat/dat64 are combinational copies of the owner's inputs.
REQ-023 wbm_ack_i, wbm_err_i and wbm_rty_i are routed combinationally to the owner's bit only; all other requesters' termination bits are 0.
REQ-024 The owner keeps the grant for as long as its req_cyc_i stays high, regardless of cab, err or rty.
REQ-025 When the owner's req_cyc_i goes low, the FSM returns to IDLE next cycle and last_owner is updated to the owner; ownership is never passed back-to-back, so there is at least one idle bus cycle between owners.
REQ-026 A requester that asserts cyc in the same cycle the owner releases is arbitrated in the following IDLE cycle.
REQ-027 A request that drops before it is granted is ignored, and no termination is sent for it.
REQ-028 rd_dat_o is valid only in cycles where the owner's ack is high.

Reset
REQ-029 On wb_rst_i: state = IDLE, grant_o = 0, last_owner = NREQ-1 (so requester 0 has first priority), tmo_o = 0, timeout counter = 0.
REQ-030 Reset asserted mid-cycle drops wbm_cyc_o at the next clock edge; no termination is forwarded in that cycle.

Configuration
REQ-031 With ADMA_ARB_TMO_EN defined:
- the counter increments while BUSY with wbm_stb_o high and no ack/err/rty, and clears on any termination or in IDLE;
- on reaching 2**TMO_W-1, the arbiter pulses req_err_o to the owner for one cycle, sets tmo_o, forces wbm_cyc_o low and returns to IDLE once the owner drops cyc.
REQ-032 Without ADMA_ARB_TMO_EN: no counter, tmo_o is absent, and a stalled slave holds the bus indefinitely.

Structure
REQ-033 adma_pkg holds the requester index constants (REQ_DESC=0, REQ_SRC=1, REQ_DST=2) and the arbiter state enum.
REQ-034 One sub-module, adma_rr_pick, performs the combinational round-robin selection (request vector and last_owner in, one-hot grant out).

Verification
REQ-035 Single owner: req 1 reads 4 beats at 0x200 -> grant_o=3'b010 one cycle after cyc; wbm_adr_o=0x200; 4 acks on req_ack_o[1] only.
REQ-036 Fairness: all three assert cyc after reset, each holding for 2 beats -> grants in order 001, 010, 100, with one idle cycle between each.
REQ-037 Rotation: req 0 releases while req 2 is pending and req 1 is idle -> wbm_cyc_o low for 1 cycle, then grant_o=3'b100.
REQ-038 Error routing: slave err on req 2 write to 0x500 -> req_err_o=3'b100 for one cycle; grant held until req 2 drops cyc.
REQ-039 Timeout (macro on, TMO_W=8): no slave response for 255 cycles -> req_err_o[owner] pulse, tmo_o=1, wbm_cyc_o=0.
REQ-040 Reset asserted mid-burst -> next cycle grant_o=0, wbm_cyc_o=0, tmo_o=0, and the next grant goes to requester 0.
